// File: rtl/bk_sum_decoder.sv
// Bit-serial inverse of the 12-bit Brent-Kung adder: recovers B = S - A and rebuilds the interleaved operand bus.
// Optional range check (err_out port) is enabled by defining BK_DEC_RANGE_CHECK_EN.
module bk_sum_decoder #(
    parameter int W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W:0]       sum_in,
    input  logic [W-1:0]     a_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     b_out,
    output logic [2*W-1:0]   operands_out
`ifdef BK_DEC_RANGE_CHECK_EN
    ,
    output logic             err_out
`endif
);

    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(input logic s, input logic a, input logic br);
        logic d;
        logic bo;
        d  = s ^ a ^ br;
        bo = (~s & a) | (~s & br) | (a & br);
        return {bo, d};
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic [W-1:0]       s_q, s_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [1:0]         cell_s;
    logic [2*W-1:0]     operands_s;

`ifdef BK_DEC_RANGE_CHECK_EN
    logic               s_top_q, s_top_d;
`else
    logic               unused_sum_msb_s;
    assign unused_sum_msb_s = sum_in[W];
`endif

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            br_q    <= 1'b0;
            s_q     <= {W{1'b0}};
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
`ifdef BK_DEC_RANGE_CHECK_EN
            s_top_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef BK_DEC_RANGE_CHECK_EN
            s_top_q <= s_top_d;
`endif
        end
    end

    // Next-state and serial subtract step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef BK_DEC_RANGE_CHECK_EN
        s_top_d = s_top_q;
`endif
        cell_s  = sub_bit(s_q[cnt_q], a_q[cnt_q], br_q);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = sum_in[W-1:0];
                    a_d     = a_in;
                    b_d     = {W{1'b0}};
                    br_d    = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
`ifdef BK_DEC_RANGE_CHECK_EN
                    s_top_d = sum_in[W];
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                b_d[cnt_q] = cell_s[0];
                br_d       = cell_s[1];
                cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Interleave held operands onto the adder's operand bus layout.
    always_comb begin
        operands_s = {(2*W){1'b0}};
        for (int i = 0; i < W; i++) begin
            operands_s[2*i]   = a_q[i];
            operands_s[2*i+1] = b_q[i];
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign b_out        = b_q;
    assign operands_out = operands_s;
`ifdef BK_DEC_RANGE_CHECK_EN
    // Carry-out set with no final borrow means overflow; borrow without carry means negative.
    assign err_out      = s_top_q ^ br_q;
`endif

endmodule
